// File: rtl/lcd_text_buffer.sv
// Character-stream front end for the 16x2 LCD: keeps a 2-row screen image with a cursor,
// accepting ASCII bytes over valid/ready and handling CR, LF, BS, FF and scroll-up.
module lcd_text_buffer #(
    parameter int          COLS      = 16,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic         clk_1MHz,
    input  logic         rst_n,
    input  logic [7:0]   char_in,
    input  logic         char_valid,
    output logic         char_ready,
    output logic [127:0] row1,
    output logic [127:0] row2,
    output logic         cursor_row,
    output logic [3:0]   cursor_col,
    output logic         updated
);

    typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_t;

    localparam logic [3:0]   LAST_COL = 4'(COLS - 1);
    localparam logic [127:0] BLANK    = {16{FILL_CHAR}};

    // Index 15 is the leftmost character, so column c lives at slot 15-c.
    logic [15:0][7:0] img1;
    logic [15:0][7:0] img2;
    state_t           state;
    logic [4:0]       sweep;
    logic             upd_pend;
    logic             accept;
    logic             printable;
    logic [3:0]       col_prev;

    assign row1      = img1;
    assign row2      = img2;
    assign accept    = char_valid && char_ready;
    assign printable = (char_in >= 8'h20) && (char_in <= 8'h7E);
    assign col_prev  = cursor_col - 4'd1;

    always_ff @(posedge clk_1MHz) begin
        if (!rst_n) begin
            img1       <= BLANK;
            img2       <= BLANK;
            cursor_row <= 1'b0;
            cursor_col <= '0;
            state      <= IDLE;
            sweep      <= '0;
            char_ready <= 1'b0;
            updated    <= 1'b0;
            upd_pend   <= 1'b0;
        end else begin
            updated  <= upd_pend;
            upd_pend <= 1'b0;
            case (state)
                IDLE: begin
                    char_ready <= 1'b1;
                    if (accept) begin
                        if (printable) begin
                            if (!cursor_row) img1[4'd15 - cursor_col] <= char_in;
                            else             img2[4'd15 - cursor_col] <= char_in;
                            if (cursor_col < LAST_COL) begin
                                cursor_col <= cursor_col + 4'd1;
                                upd_pend   <= 1'b1;
                            end else if (!cursor_row) begin
                                cursor_row <= 1'b1;
                                cursor_col <= '0;
                                upd_pend   <= 1'b1;
                            end else begin
                                // Wrap off the last row: the scroll cycle reports the change.
                                cursor_col <= '0;
                                state      <= SCROLL;
                                char_ready <= 1'b0;
                            end
                        end else begin
                            case (char_in)
                                8'h0D: cursor_col <= '0;
                                8'h0A: begin
                                    if (!cursor_row) begin
                                        cursor_row <= 1'b1;
                                    end else begin
                                        state      <= SCROLL;
                                        char_ready <= 1'b0;
                                    end
                                end
                                8'h08: begin
                                    if (cursor_col != 4'd0) begin
                                        cursor_col <= col_prev;
                                        if (!cursor_row) img1[4'd15 - col_prev] <= FILL_CHAR;
                                        else             img2[4'd15 - col_prev] <= FILL_CHAR;
                                        upd_pend <= 1'b1;
                                    end
                                end
                                8'h0C: begin
                                    state      <= CLEAR;
                                    sweep      <= '0;
                                    char_ready <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                SCROLL: begin
                    img1       <= img2;
                    img2       <= BLANK;
                    cursor_row <= 1'b1;
                    state      <= IDLE;
                    char_ready <= 1'b1;
                    upd_pend   <= 1'b1;
                end
                CLEAR: begin
                    if (!sweep[4]) img1[4'd15 - sweep[3:0]] <= FILL_CHAR;
                    else           img2[4'd15 - sweep[3:0]] <= FILL_CHAR;
                    sweep <= sweep + 5'd1;
                    if (sweep == 5'd31) begin
                        cursor_row <= 1'b0;
                        cursor_col <= '0;
                        state      <= IDLE;
                        char_ready <= 1'b1;
                        upd_pend   <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    char_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Bench for lcd_text_buffer: behavioural screen model feeding a scoreboard queue,
// a table of byte vectors, and hand sequences for scroll, clear and mid-clear reset.
module tb_lcd_text_buffer;

    localparam int COLS = 16;
    localparam logic [127:0] BLANK = {16{8'h20}};

    logic         clk_1MHz = 1'b0;
    logic         rst_n    = 1'b0;
    logic [7:0]   char_in  = 8'h00;
    logic         char_valid = 1'b0;
    logic         char_ready;
    logic [127:0] row1, row2;
    logic         cursor_row;
    logic [3:0]   cursor_col;
    logic         updated;

    lcd_text_buffer #(.COLS(COLS), .FILL_CHAR(8'h20)) dut (
        .clk_1MHz   (clk_1MHz),
        .rst_n      (rst_n),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .row1       (row1),
        .row2       (row2),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .updated    (updated)
    );

    always #500 clk_1MHz = ~clk_1MHz;

    int tests = 0;
    int fails = 0;
    int upd_cnt = 0;

    always @(negedge clk_1MHz) if (updated === 1'b1) upd_cnt++;

    typedef struct {
        logic [7:0] ch;
        logic       exp_row;
        logic [3:0] exp_col;
        int         exp_pulses;
        int         exp_low;
    } vec_t;

    typedef struct {
        logic [127:0] r1;
        logic [127:0] r2;
        logic         row;
        logic [3:0]   col;
        int           pulses;
        int           low;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m1 [16];
    logic [7:0] m2 [16];
    logic       mr;
    int         mc;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic [7:0] m [16]);
        logic [127:0] v;
        for (int c = 0; c < 16; c++) v[127 - 8*c -: 8] = m[c];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin m1[i] = 8'h20; m2[i] = 8'h20; end
        mr = 1'b0;
        mc = 0;
    endtask

    task automatic model_scroll();
        for (int i = 0; i < 16; i++) begin m1[i] = m2[i]; m2[i] = 8'h20; end
    endtask

    task automatic model_apply(input logic [7:0] b, output int pulses, output int low);
        pulses = 0;
        low    = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            if (!mr) m1[mc] = b; else m2[mc] = b;
            pulses = 1;
            if (mc < COLS - 1) mc++;
            else if (!mr) begin mr = 1'b1; mc = 0; end
            else begin mc = 0; model_scroll(); low = 1; end
        end else begin
            case (b)
                8'h0D: mc = 0;
                8'h0A: if (!mr) mr = 1'b1; else begin model_scroll(); pulses = 1; low = 1; end
                8'h08: if (mc > 0) begin
                    mc--;
                    if (!mr) m1[mc] = 8'h20; else m2[mc] = 8'h20;
                    pulses = 1;
                end
                8'h0C: begin model_reset(); pulses = 1; low = 32; end
                default: ;
            endcase
        end
    endtask

    task automatic send(input logic [7:0] b, input string nm);
        exp_t e;
        int p, lw, lowcnt, u0, t;
        model_apply(b, p, lw);
        e.r1 = pack(m1); e.r2 = pack(m2); e.row = mr; e.col = 4'(mc);
        e.pulses = p; e.low = lw;
        sb.push_back(e);
        t = 0;
        while (char_ready !== 1'b1 && t < 200) begin @(negedge clk_1MHz); t++; end
        if (t >= 200) begin
            tests++; fails++;
            $display("FAIL %s ready_timeout: char_ready never rose", nm);
        end
        char_in = b; char_valid = 1'b1; u0 = upd_cnt;
        @(negedge clk_1MHz);
        char_valid = 1'b0;
        lowcnt = 0;
        while (char_ready !== 1'b1 && lowcnt < 200) begin lowcnt++; @(negedge clk_1MHz); end
        repeat (2) @(negedge clk_1MHz);
        e = sb.pop_front();
        chk({nm, " row1"}, row1, e.r1);
        chk({nm, " row2"}, row2, e.r2);
        chk({nm, " cursor"}, {cursor_row, cursor_col}, {e.row, e.col});
        chk({nm, " updated_pulses"}, 128'(upd_cnt - u0), 128'(e.pulses));
        chk({nm, " ready_low_cycles"}, 128'(lowcnt), 128'(e.low));
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0; char_valid = 1'b0;
        repeat (2) @(negedge clk_1MHz);
        chk({nm, " rst row1"}, row1, BLANK);
        chk({nm, " rst row2"}, row2, BLANK);
        chk({nm, " rst cursor/ready/upd"}, {cursor_row, cursor_col, char_ready, updated}, '0);
        rst_n = 1'b1;
        @(negedge clk_1MHz);
        chk({nm, " ready after release"}, 128'(char_ready), 128'(1));
        model_reset();
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[10];
        string s_low, s_up;
        int dummy_p, dummy_l, lowcnt, u0;

        vt[0] = '{8'h41, 1'b0, 4'd1, 1, 0};   // 'A'
        vt[1] = '{8'h42, 1'b0, 4'd2, 1, 0};   // 'B'
        vt[2] = '{8'h0D, 1'b0, 4'd0, 0, 0};   // CR
        vt[3] = '{8'h0A, 1'b1, 4'd0, 0, 0};   // LF on top row
        vt[4] = '{8'h43, 1'b1, 4'd1, 1, 0};   // 'C'
        vt[5] = '{8'h08, 1'b1, 4'd0, 1, 0};   // BS
        vt[6] = '{8'h08, 1'b1, 4'd0, 0, 0};   // BS at col 0
        vt[7] = '{8'h01, 1'b1, 4'd0, 0, 0};   // dropped byte
        vt[8] = '{8'h0A, 1'b1, 4'd0, 1, 1};   // LF on bottom row scrolls
        vt[9] = '{8'h0C, 1'b0, 4'd0, 1, 32};  // FF

        model_reset();
        do_reset("t1");

        for (int i = 0; i < 10; i++) begin
            send(vt[i].ch, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d table_cursor", i), {cursor_row, cursor_col},
                {vt[i].exp_row, vt[i].exp_col});
        end

        // 16 x 'X' then 'Y' from home
        for (int i = 0; i < 16; i++) send(8'h58, "fillX");
        send(8'h59, "Y");
        chk("t2 row1", row1, {16{8'h58}});
        chk("t2 row2 lead", 128'(row2[127:120]), 128'(8'h59));
        chk("t2 cursor", {cursor_row, cursor_col}, {1'b1, 4'd1});

        // full screen then wrap scroll
        do_reset("t3");
        s_low = "abcdefghijklmnop";
        s_up  = "ABCDEFGHIJKLMNOP";
        for (int i = 0; i < 16; i++) send(s_low[i], "lower");
        for (int i = 0; i < 16; i++) send(s_up[i], "upper");
        send(8'h5A, "Z wrap");
        chk("t3 row1", row1, "ABCDEFGHIJKLMNOP");
        chk("t3 row2", row2, {8'h5A, {15{8'h20}}});
        chk("t3 cursor", {cursor_row, cursor_col}, {1'b1, 4'd1});

        // BS sequence
        do_reset("t5");
        send(8'h41, "t5 A");
        send(8'h42, "t5 B");
        send(8'h08, "t5 BS1");
        send(8'h08, "t5 BS2");
        send(8'h08, "t5 BS3");
        chk("t5 row1", row1, BLANK);

        // FF with 'Q' held on the bus during the clear
        do_reset("t4");
        send(8'h48, "t4 H");
        send(8'h49, "t4 I");
        model_apply(8'h0C, dummy_p, dummy_l);
        model_apply(8'h51, dummy_p, dummy_l);
        char_in = 8'h0C; char_valid = 1'b1;
        @(negedge clk_1MHz);
        char_in = 8'h51;
        lowcnt = 0;
        while (char_ready !== 1'b1 && lowcnt < 200) begin lowcnt++; @(negedge clk_1MHz); end
        chk("t4 clear_low_cycles", 128'(lowcnt), 128'(32));
        chk("t4 cleared rows", {row1, row2}, {BLANK, BLANK});
        @(negedge clk_1MHz);
        char_valid = 1'b0;
        repeat (2) @(negedge clk_1MHz);
        chk("t4 row1 Q", row1, {8'h51, {15{8'h20}}});
        chk("t4 model row1", row1, pack(m1));
        chk("t4 cursor", {cursor_row, cursor_col}, {1'b0, 4'd1});

        // reset in the middle of CLEAR, with bottom-row content not yet swept
        do_reset("t6");
        send(8'h41, "t6 A");
        send(8'h42, "t6 B");
        send(8'h0A, "t6 LF");
        send(8'h43, "t6 C");
        send(8'h44, "t6 D");
        char_in = 8'h0C; char_valid = 1'b1;
        @(negedge clk_1MHz);
        char_valid = 1'b0;
        repeat (10) @(negedge clk_1MHz);
        rst_n = 1'b0;
        u0 = upd_cnt;
        @(negedge clk_1MHz);
        chk("t6 rows after abort", {row1, row2}, {BLANK, BLANK});
        chk("t6 cursor/ready/upd", {cursor_row, cursor_col, char_ready, updated}, '0);
        rst_n = 1'b1;
        @(negedge clk_1MHz);
        chk("t6 ready after release", 128'(char_ready), 128'(1));
        repeat (3) @(negedge clk_1MHz);
        chk("t6 no stray update", 128'(upd_cnt - u0), 128'(0));
        model_reset();
        send(8'h4B, "t6 K");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
